// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers: default formats, derived widths and the
// quantisation function used by the datapath blocks.
package fixed_pkg;

    // Default operand/result formats
    localparam int unsigned DEF_NBA  = 12;
    localparam int unsigned DEF_NBFA = 11;
    localparam int unsigned DEF_NBB  = 8;
    localparam int unsigned DEF_NBFB = 6;
    localparam int unsigned DEF_NBS  = 10;
    localparam int unsigned DEF_NBFS = 9;

    // Integer (sign + magnitude) bits of each format and LSBs dropped
    localparam int unsigned NEA = DEF_NBA - DEF_NBFA;
    localparam int unsigned NEB = DEF_NBB - DEF_NBFB;
    localparam int unsigned NES = DEF_NBS - DEF_NBFS;
    localparam int unsigned D   = DEF_NBFA + DEF_NBFB - DEF_NBFS;

    // Saturation limits of the default output format
    localparam logic [DEF_NBS-1:0] MAXV = {1'b0, {(DEF_NBS-1){1'b1}}};
    localparam logic [DEF_NBS-1:0] MINV = {1'b1, {(DEF_NBS-1){1'b0}}};

    // Working width of fx_quant; every supported product fits with headroom
    localparam int unsigned FXW = 64;

    typedef struct packed {
        logic           ovf;
        logic [FXW-1:0] data;
    } fx_res_t;

    // Quantise a sign-extended product p by dropping d LSBs into an nbs-bit
    // result. Data is returned sign-extended; callers keep the low nbs bits.
    function automatic fx_res_t fx_quant(input logic signed [FXW-1:0] p,
                                         input logic                  rnd,
                                         input logic                  sat,
                                         input int unsigned           d,
                                         input int unsigned           nbs);
        logic signed [FXW-1:0] q;
        logic signed [FXW-1:0] maxv;
        logic signed [FXW-1:0] minv;
        fx_res_t               r;
        q = p;
        if (rnd && (d > 0)) begin
            q = p + (64'sd1 <<< (d - 1));
        end
        q = q >>> d;
        // The wide working width keeps the rounding carry, so range check = overflow
        maxv  = (64'sd1 <<< (nbs - 1)) - 64'sd1;
        minv  = -(64'sd1 <<< (nbs - 1));
        r.ovf = (q > maxv) || (q < minv);
        if (sat && r.ovf) begin
            r.data = q[FXW-1] ? minv : maxv;
        end else begin
            r.data = q;
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_quantizer.sv
// Combinational round/saturate stage: S(NBP,NBFP) product -> S(NBS,NBFS).
module fixed_quantizer
    import fixed_pkg::*;
#(
    parameter int unsigned NBP  = 20,
    parameter int unsigned NBFP = 17,
    parameter int unsigned NBS  = 10,
    parameter int unsigned NBFS = 9
) (
    input  logic [NBP-1:0] i_p,
    input  logic           i_round,
    input  logic           i_sat,
    output logic [NBS-1:0] o_data,
    output logic           o_ovf
);

    logic [FXW-1:0] w_p_ext;
    fx_res_t        w_res;
    logic           w_unused_hi;

    // Sign-extend the product and apply the selected rounding/overflow policy
    always_comb begin
        w_p_ext = {{(FXW-NBP){i_p[NBP-1]}}, i_p};
        w_res   = fx_quant(w_p_ext, i_round, i_sat, NBFP - NBFS, NBS);
        o_data  = w_res.data[NBS-1:0];
        o_ovf   = w_res.ovf;
    end

    // Upper bits are only the sign extension of o_data
    assign w_unused_hi = ^w_res.data[FXW-1:NBS];

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready flow control,
// per-sample round/saturate modes and a saturating overflow counter.
module fixed_mult_pipe
    import fixed_pkg::*;
#(
    parameter int unsigned NBA   = DEF_NBA,
    parameter int unsigned NBFA  = DEF_NBFA,
    parameter int unsigned NBB   = DEF_NBB,
    parameter int unsigned NBFB  = DEF_NBFB,
    parameter int unsigned NBS   = DEF_NBS,
    parameter int unsigned NBFS  = DEF_NBFS,
    parameter int unsigned NBCNT = 16
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NBA-1:0]     i_a,
    input  logic [NBB-1:0]     i_b,
    input  logic               i_round,
    input  logic               i_sat,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NBS-1:0]     o_data,
    output logic [NBA+NBB-1:0] o_full,
    output logic               o_ovf,
    input  logic               i_cnt_clr,
    output logic [NBCNT-1:0]   o_ovf_cnt
);

    localparam int unsigned NBP = NBA + NBB;

    logic                  w_en;
    logic                  w_out_xfer;
    logic signed [NBP-1:0] w_prod;
    logic [NBS-1:0]        w_q_data;
    logic                  w_q_ovf;

    logic                  r_v1;
    logic [NBA-1:0]        r_a;
    logic [NBB-1:0]        r_b;
    logic                  r_rnd1;
    logic                  r_sat1;

    logic                  r_v2;
    logic [NBP-1:0]        r_p;
    logic                  r_rnd2;
    logic                  r_sat2;

    logic                  r_v3;
    logic [NBS-1:0]        r_data;
    logic [NBP-1:0]        r_full;
    logic                  r_ovf;

    logic [NBCNT-1:0]      r_cnt;

    // The whole pipe moves together whenever the output slot is free or draining
    assign w_en       = ~r_v3 | i_ready;
    assign w_out_xfer = r_v3 & i_ready;

    // Full-precision signed product; operands pre-extended so nothing can overflow
    always_comb begin
        w_prod = $signed({{NBB{r_a[NBA-1]}}, r_a}) * $signed({{NBA{r_b[NBB-1]}}, r_b});
    end

    fixed_quantizer #(
        .NBP  (NBP),
        .NBFP (NBFA + NBFB),
        .NBS  (NBS),
        .NBFS (NBFS)
    ) u_quant (
        .i_p     (r_p),
        .i_round (r_rnd2),
        .i_sat   (r_sat2),
        .o_data  (w_q_data),
        .o_ovf   (w_q_ovf)
    );

    // S1: capture operands together with their mode bits
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_v1   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_rnd1 <= 1'b0;
            r_sat1 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= i_valid;
            r_a    <= i_a;
            r_b    <= i_b;
            r_rnd1 <= i_round;
            r_sat1 <= i_sat;
        end
    end

    // S2: register the full product, modes follow their sample
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_v2   <= 1'b0;
            r_p    <= '0;
            r_rnd2 <= 1'b0;
            r_sat2 <= 1'b0;
        end else if (w_en) begin
            r_v2   <= r_v1;
            r_p    <= w_prod;
            r_rnd2 <= r_rnd1;
            r_sat2 <= r_sat1;
        end
    end

    // S3: register the quantised result; held while downstream stalls
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_v3   <= 1'b0;
            r_data <= '0;
            r_full <= '0;
            r_ovf  <= 1'b0;
        end else if (w_en) begin
            r_v3   <= r_v2;
            r_data <= w_q_data;
            r_full <= r_p;
            r_ovf  <= w_q_ovf;
        end
    end

    // Overflow counter: clear beats increment, sticks at all ones
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_xfer && r_ovf && (r_cnt != {NBCNT{1'b1}})) begin
            r_cnt <= r_cnt + NBCNT'(1);
        end
    end

    assign o_ready   = w_en;
    assign o_valid   = r_v3;
    assign o_data    = r_data;
    assign o_full    = r_full;
    assign o_ovf     = r_ovf;
    assign o_ovf_cnt = r_cnt;

endmodule

// File: doc/fixed_mult_pipe.md
Name: fixed_mult_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier with a valid/ready stream interface. It computes the full S(NBA+NBB, NBFA+NBFB) product and quantises it to a configurable S(NBS, NBFS) output. Truncate/round and wrap/saturate are selected per sample. A per-sample overflow flag and a saturating overflow counter are provided. The block sits between the fixed-point datapath stages (filters, equalisers) of the baseband chain.

Parameters:
NBA, 12, total bits of operand A
NBFA, 11, fractional bits of operand A
NBB, 8, total bits of operand B
NBFB, 6, fractional bits of operand B
NBS, 10, total bits of output
NBFS, 9, fractional bits of output; constraints: NBFS <= NBFA+NBFB and (NBS-NBFS) <= (NBA-NBFA)+(NBB-NBFB)
NBCNT, 16, width of overflow counter

Ports:
clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous active-high reset
i_valid  in  1  input sample valid
o_ready  out  1  block accepts input this cycle
i_a  in  NBA  operand A, signed S(NBA,NBFA)
i_b  in  NBB  operand B, signed S(NBB,NBFB)
i_round  in  1  0 = truncate (floor), 1 = round half-up; sampled with data
i_sat  in  1  0 = wrap, 1 = saturate; sampled with data
o_valid  out  1  output sample valid
i_ready  in  1  downstream accepts output
o_data  out  NBS  quantised product S(NBS,NBFS)
o_full  out  NBA+NBB  full-precision product of the same sample
o_ovf  out  1  sample's quantisation overflowed (either mode)
i_cnt_clr  in  1  clear overflow counter
o_ovf_cnt  out  NBCNT  overflow count, saturating

Behaviour:
- Reset: all stage valids, o_valid, o_data, o_full, o_ovf and o_ovf_cnt go to 0. Reset mid-stream discards all in-flight samples.
- Pipeline: S1 registers the operands and mode bits. S2 registers the full product. S3 registers the quantised result. Latency is 3 cycles from accepted input to o_valid.
- Flow control: en = ~o_valid | i_ready, and o_ready = en. When en=1, all stages advance together and bubbles propagate as valid=0. When en=0, every register holds its value.
- Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
- While o_valid=1 and i_ready=0, o_data, o_full and o_ovf stay stable.
- Full product: P = i_a * i_b, signed, NBA+NBB bits, with NBFA+NBFB fractional bits. No overflow is possible.
- Quantisation: D = NBFA+NBFB-NBFS LSBs are dropped.
  - Round mode with D>0: Q = (P + 2^(D-1)) >>> D, computed in NBA+NBB+1 bits. Ties go toward +inf.
  - Truncate mode, or D=0: Q = P >>> D (floor).
- Overflow: set when the bits of Q above NBS-1 are not all equal to Q[NBS-1]. The carry bit from rounding is included in this check.
- Output selection:
  - Wrap: o_data = Q[NBS-1:0].
  - Saturate with overflow: positive Q gives max {0, all ones}; negative Q gives min {1, all zeros}. Both are NBS wide and derived from the parameters only.
  - o_ovf reports overflow in both modes.
- Counter: increments on an output transfer with o_ovf=1. It holds at 2^NBCNT-1.
  - i_cnt_clr sets the counter to 0 next cycle.
  - When clear and increment happen in the same cycle, clear wins (result 0).
- Mode bits travel with their sample. Changing i_round/i_sat never affects in-flight samples.

Decomposition:
- Shared package fixed_pkg holds:
  - function fx_quant(P, round, sat) returning {ovf, data}, parametrised by widths.
  - localparams NEA, NEB, NES, D, MAXV, MINV.
- One sub-module is natural: fixed_quantizer, the combinational round/saturate stage used by S3, which is reusable by other datapath blocks.
- The pipeline registers and the counter stay in the top module.

Test Plan:
- Basic, defaults, i_round=0, i_sat=1, i_ready=1: a=0x400 (0.5), b=0x40 (1.0) -> after 3 cycles o_full=65536, o_data=0x100, o_ovf=0.
- Overflow: a=0x800 (-1), b=0x80 (-2), product +2.0 -> with sat=1: o_data=0x1FF, o_ovf=1. With sat=0: o_data=0x000, o_ovf=1. o_ovf_cnt increments to 2.
- Rounding ties:
  - a=2, b=64 (P=128): round=1 -> 0x001; round=0 -> 0x000.
  - a=0xFFE, b=64 (P=-128): round=1 -> 0x000; round=0 -> 0x3FF.
- Backpressure: stream 5 samples, drop i_ready for 4 cycles mid-stream -> o_ready=0, o_data/o_full/o_ovf frozen, no loss or duplication, order preserved, throughput 1/cycle otherwise.
- Counter: with NBCNT=2, drive 5 overflowing samples -> count stops at 3. Assert i_cnt_clr together with an overflowing transfer -> count=0.
- Reset with 3 samples in flight -> o_valid=0 next cycle, o_ovf_cnt=0, no stale outputs after reset release.
